// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a one-cycle-latency FIFO into a valid/ready stream
// A two-slot skid buffer absorbs the read latency so the stream sustains one word per cycle.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;

  logic                  pop;
  logic [2:0]            committed;
  logic [1:0]            occ_after_pop;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH-1:0] head_next;
  logic [DATA_WIDTH-1:0] tail_next;

  assign pop    = m_valid & m_ready;
  assign m_data = head;

  // Slots already spoken for after this cycle's pop; at most one more read may be issued.
  assign committed     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_r_en     = ~rst & ~fifo_empty & (committed <= 3'd1);
  assign occ_after_pop = occ - {1'b0, pop};
  assign occ_next      = occ_after_pop + {1'b0, inflight};

  always_comb begin
    head_next = head;
    tail_next = tail;
    if (pop) begin
      head_next = tail;
    end
    // The returning word lands in the first slot left free once the pop is applied.
    if (inflight) begin
      if (occ_after_pop == 2'd0) begin
        head_next = fifo_rdata;
      end else begin
        tail_next = fifo_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      m_valid    <= 1'b0;
      xfer_count <= '0;
    end else begin
      occ        <= occ_next;
      inflight   <= fifo_r_en;
      head       <= head_next;
      tail       <= tail_next;
      m_valid    <= (occ_next != 2'd0);
      xfer_count <= xfer_count + {{(CNT_WIDTH-1){1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_ready;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty;
  logic        fifo_r_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] xfer_count;
  logic        fifo_r_en4;
  logic        m_valid4;
  logic [7:0]  m_data4;
  logic [3:0]  xfer_count4;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .xfer_count(xfer_count)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_r_en(fifo_r_en4), .m_valid(m_valid4), .m_data(m_data4),
    .m_ready(m_ready), .xfer_count(xfer_count4)
  );

  // FIFO model: one-cycle read latency, push side written only by the stimulus block
  logic [7:0] mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_rdata <= mem[pop_cnt[7:0]];
      pop_cnt    <= pop_cnt + 1;
    end
  end

  // Stream monitor
  logic [7:0] out_d [0:255];
  int         out_c [0:255];
  int         cyc = 0;
  int         out_n = 0;
  int         ren_n = 0;
  int         max_sum = 0;
  int         stall_bad = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_r_en) ren_n <= ren_n + 1;
    if (!rst && m_valid && m_ready) begin
      out_d[out_n[7:0]] <= m_data;
      out_c[out_n[7:0]] <= cyc;
      out_n <= out_n + 1;
    end
    if (int'(dut.occ) + int'(dut.inflight) > max_sum)
      max_sum <= int'(dut.occ) + int'(dut.inflight);
    if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data))
      stall_bad <= stall_bad + 1;
    prev_stall <= m_valid && !m_ready && !rst;
    prev_data  <= m_data;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[push_cnt[7:0]] = v;
    push_cnt++;
  endtask

  int ob;
  int br;
  int remaining;

  initial begin
    rst = 1'b1;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset held with a non-empty FIFO
    push(8'hA5);
    #1;
    chk("rst_ren", fifo_r_en, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 8'h00);
    chk("rst_xfer", xfer_count, 0);

    // Single word: valid exactly two cycles after the read pulse
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    br = ren_n;
    #1;
    chk("single_ren", fifo_r_en, 1);
    @(posedge clk); #1;
    chk("single_valid_t1", m_valid, 0);
    chk("single_ren_t1", fifo_r_en, 0);
    @(posedge clk); #1;
    chk("single_valid_t2", m_valid, 1);
    chk("single_data_t2", m_data, 8'hA5);
    @(posedge clk); #1;
    chk("single_valid_t3", m_valid, 0);
    chk("single_xfer", xfer_count, 1);
    chk("single_ren_pulses", ren_n - br, 1);

    // Streaming 0x01..0x08 back to back
    @(negedge clk);
    ob = out_n;
    for (int v = 1; v <= 8; v++) push(8'(v));
    repeat (14) @(posedge clk);
    #1;
    chk("stream_count", out_n - ob, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("stream_word%0d", k), out_d[ob + k], k + 1);
      chk($sformatf("stream_gap%0d", k), out_c[ob + k] - out_c[ob], k);
    end
    chk("stream_xfer", xfer_count, 9);
    chk("stream_empty", fifo_empty, 1);

    // Backpressure: two reads land, head holds 0x11
    @(negedge clk);
    m_ready = 1'b0;
    ob = out_n;
    br = ren_n;
    for (int v = 8'h11; v <= 8'h14; v++) push(8'(v));
    repeat (10) @(posedge clk);
    #1;
    chk("bp_ren_pulses", ren_n - br, 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h11);
    chk("bp_no_pop", out_n - ob, 0);
    @(negedge clk);
    m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_count", out_n - ob, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp_word%0d", k), out_d[ob + k], 8'h11 + k);
    chk("bp_xfer", xfer_count, 13);

    // Alternating ready over 0x20..0x2F
    @(negedge clk);
    ob = out_n;
    for (int v = 8'h20; v <= 8'h2F; v++) push(8'(v));
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("alt_count", out_n - ob, 16);
    for (int k = 0; k < 16; k++)
      chk($sformatf("alt_word%0d", k), out_d[ob + k], 8'h20 + k);
    chk("alt_xfer", xfer_count, 29);
    chk("occ_inflight_max", max_sum <= 2, 1);
    chk("stall_stable", stall_bad, 0);

    // Asynchronous reset mid-stream, then 17 transfers to wrap the 4-bit counter
    @(negedge clk);
    for (int v = 8'h40; v <= 8'h45; v++) push(8'(v));
    repeat (3) @(posedge clk);
    #3;
    chk("mid_valid_before", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_xfer", xfer_count, 0);
    chk("mid_rst_ren", fifo_r_en, 0);
    chk("mid_rst_xfer4", xfer_count4, 0);
    @(negedge clk);
    rst = 1'b0;
    remaining = push_cnt - pop_cnt;
    for (int k = remaining; k < 17; k++) push(8'(8'h60 + k));
    repeat (30) @(posedge clk);
    #1;
    chk("wrap_xfer16", xfer_count, 17);
    chk("wrap_xfer4", xfer_count4, 1);
    chk("wrap_empty", fifo_empty, 1);
    chk("wrap_valid", m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
